// File: rtl/vu_vmu_ut_issue.sv
// UT load issue stage: walks the elements of each issue command, adds the popped
// per-element offset to the command base and emits tagged load requests through a one-entry register.
module vu_vmu_ut_issue #(
    parameter int ADDR_SZ = 64,
    parameter int VLEN_SZ = 11
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_SZ+VLEN_SZ-1:0] iscmdq_deq_bits,
    input  logic                       iscmdq_deq_val,
    output logic                       iscmdq_deq_rdy,
    input  logic [ADDR_SZ-1:0]         utaq_deq_bits,
    input  logic                       utaq_deq_val,
    output logic                       utaq_deq_rdy,
    output logic [ADDR_SZ-1:0]         memreq_bits_addr,
    output logic [VLEN_SZ-1:0]         memreq_bits_tag,
    output logic                       memreq_val,
    input  logic                       memreq_rdy,
    output logic                       issue_busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic                 r_out_val;
    logic [ADDR_SZ-1:0]   r_out_addr;
    logic [VLEN_SZ-1:0]   r_out_tag;
    logic [VLEN_SZ-1:0]   r_cnt;
    logic [ADDR_SZ-1:0]   r_base;
    logic [VLEN_SZ-1:0]   r_vlen;

    logic                 w_can_load;
    logic                 w_cmd_fire;
    logic                 w_elem_fire;
    logic                 w_last;
    logic [ADDR_SZ-1:0]   w_cmd_addr;
    logic [VLEN_SZ-1:0]   w_cmd_vlen;

    assign w_cmd_addr  = iscmdq_deq_bits[ADDR_SZ+VLEN_SZ-1:VLEN_SZ];
    assign w_cmd_vlen  = iscmdq_deq_bits[VLEN_SZ-1:0];
    assign w_can_load  = ~r_out_val | memreq_rdy;
    assign w_cmd_fire  = iscmdq_deq_val & iscmdq_deq_rdy;
    assign w_elem_fire = utaq_deq_val & utaq_deq_rdy;
    assign w_last      = (r_cnt == r_vlen);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_cmd_fire)            w_state_next = S_ISSUE;
            S_ISSUE: if (w_elem_fire && w_last) w_state_next = S_IDLE;
            default:                            w_state_next = S_IDLE;
        endcase
    end

    // Handshake outputs; a new command waits for the previous last request to drain
    always_comb begin
        iscmdq_deq_rdy = 1'b0;
        utaq_deq_rdy   = 1'b0;
        case (r_state)
            S_IDLE:  iscmdq_deq_rdy = ~r_out_val;
            S_ISSUE: utaq_deq_rdy   = w_can_load;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_val  <= 1'b0;
            r_out_addr <= '0;
            r_out_tag  <= '0;
            r_cnt      <= '0;
            r_base     <= '0;
            r_vlen     <= '0;
        end else begin
            if (w_cmd_fire) begin
                r_base <= w_cmd_addr;
                r_vlen <= w_cmd_vlen;
                r_cnt  <= '0;
            end
            // A fire in the same cycle as a drain refills the register: 1 element/cycle
            if (w_elem_fire) begin
                r_out_val  <= 1'b1;
                r_out_addr <= r_base + utaq_deq_bits;
                r_out_tag  <= r_cnt;
                r_cnt      <= w_last ? '0 : r_cnt + {{(VLEN_SZ-1){1'b0}}, 1'b1};
            end else if (memreq_rdy && r_out_val) begin
                r_out_val <= 1'b0;
            end
        end
    end

    assign memreq_val       = r_out_val;
    assign memreq_bits_addr = r_out_addr;
    assign memreq_bits_tag  = r_out_tag;
    assign issue_busy       = (r_state == S_ISSUE) | r_out_val | iscmdq_deq_val;

`ifndef SYNTHESIS
    // Offsets sitting in utaq with no command to consume them point to a VXU/VMU mismatch
    logic [10:0] r_orphan_cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_orphan_cnt <= '0;
        end else if (r_state == S_IDLE && utaq_deq_val) begin
            if (r_orphan_cnt != 11'd1025) r_orphan_cnt <= r_orphan_cnt + 11'd1;
            if (r_orphan_cnt == 11'd1024)
                $display("vu_vmu_ut_issue: error: utaq_deq_val high in IDLE for over 1024 cycles (orphan offsets)");
        end else begin
            r_orphan_cnt <= '0;
        end
    end
`endif

endmodule
